// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction memory request/ack port plus the head-of-queue view the control unit consumes.
// master = fetch unit, slave = memory/control side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 5
) ();
  logic               MemReq;
  logic [ADDR_W-1:0]  MemAddr;
  logic               MemAck;
  logic [INSTR_W-1:0] MemData;
  logic               PCWrite;
  logic [ADDR_W-1:0]  PCIn;
  logic               InstrTake;
  logic               InstrReady;
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  InstrPC;
  logic [OPC_W-1:0]   OPCODE;
  logic               flagbit;

  modport master (
    output MemReq, MemAddr, InstrReady, Instr, InstrPC, OPCODE, flagbit,
    input  MemAck, MemData, PCWrite, PCIn, InstrTake
  );

  modport slave (
    input  MemReq, MemAddr, InstrReady, Instr, InstrPC, OPCODE, flagbit,
    output MemAck, MemData, PCWrite, PCIn, InstrTake
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end with a 2-entry prefetch queue; ack in cycle t shows as InstrReady in t+1.
// Stops requesting while the queue is full; a redirect flushes the queue and drains any outstanding request.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                OPC_HI   = 15,
  parameter int                OPC_LO   = 11,
  parameter int                FLAG_POS = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                Reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD} state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
  logic [1:0]        count_q, count_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  entry_t            new_ent;
  logic              push, pop;
  logic              head_vld;
  logic [INSTR_W-1:0] instr_w;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_REQ;
      fpc_q       <= RESET_PC;
      disc_addr_q <= '0;
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      disc_addr_q <= disc_addr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    disc_addr_d = disc_addr_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    push        = 1'b0;
    pop         = 1'b0;
    new_ent     = {bus.MemData, fpc_q};

    if (bus.PCWrite) begin
      count_d = 2'd0;
      fpc_d   = bus.PCIn;
      case (state_q)
        S_REQ: begin
          // Without an ack the old request is still in flight; keep its address on the bus until it returns.
          if (bus.MemAck) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_DISCARD;
            disc_addr_d = fpc_q;
          end
        end
        S_HOLD:    state_d = S_REQ;
        S_DISCARD: state_d = bus.MemAck ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      push = (state_q == S_REQ) && bus.MemAck;
      pop  = bus.InstrTake && (count_q != 2'd0);

      if (push) fpc_d = fpc_q + ADDR_W'(1);
      if (pop) head_d = tail_q;
      if (push) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) head_d = new_ent;
        else                                                 tail_d = new_ent;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase

      if (state_q == S_DISCARD) begin
        if (bus.MemAck) state_d = S_REQ;
      end else begin
        state_d = (count_d == 2'd2) ? S_HOLD : S_REQ;
      end
    end
  end

  assign head_vld       = (count_q != 2'd0);
  assign instr_w        = head_vld ? head_q.word : '0;
  assign bus.MemReq     = (state_q != S_HOLD) && !Reset;
  assign bus.MemAddr    = (state_q == S_DISCARD) ? disc_addr_q : fpc_q;
  assign bus.InstrReady = head_vld;
  assign bus.Instr      = instr_w;
  assign bus.InstrPC    = head_vld ? head_q.pc : '0;
  assign bus.OPCODE     = instr_w[OPC_HI:OPC_LO];
  assign bus.flagbit    = instr_w[FLAG_POS];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model returns word = address + mem_off after mem_lat wait cycles.
module tb_instr_fetch_unit;

  logic CLK = 1'b0;
  logic Reset;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wait_cnt = 0;
  int          mem_lat  = 0;
  bit          mem_en   = 1'b0;
  logic [15:0] mem_off  = 16'h0000;
  bit          ack_c;
  bit          req_c;

  // Inputs for the current cycle are decided here, then outputs are sampled at the falling edge.
  task automatic cyc_begin();
    #1;
    bus.MemAck  = mem_en && bus.MemReq && (wait_cnt >= mem_lat);
    bus.MemData = bus.MemAck ? (bus.MemAddr + mem_off) : 16'h0000;
    ack_c = bus.MemAck;
    req_c = bus.MemReq;
    @(negedge CLK);
  endtask

  task automatic cyc_end();
    @(posedge CLK);
    if (ack_c || Reset) wait_cnt = 0;
    else if (req_c)     wait_cnt++;
    #1;
    bus.PCWrite   = 1'b0;
    bus.InstrTake = 1'b0;
    bus.MemAck    = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    cyc_begin();
    cyc_end();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_en = 1'b0;
    Reset  = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b0) $display("FAIL rst_memreq: got %b exp 0", bus.MemReq); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL rst_ready: got %b exp 0", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.Instr !== 16'h0000) $display("FAIL rst_instr: got %h exp 0000", bus.Instr); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0000) $display("FAIL rst_instrpc: got %h exp 0000", bus.InstrPC); else n_pass++;
    n_checks++; if (bus.OPCODE !== 5'h00) $display("FAIL rst_opcode: got %h exp 00", bus.OPCODE); else n_pass++;
    n_checks++; if (bus.flagbit !== 1'b0) $display("FAIL rst_flag: got %b exp 0", bus.flagbit); else n_pass++;
    cyc_end();
    Reset = 1'b0;
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b1) $display("FAIL rst_first_req: got %b exp 1", bus.MemReq); else n_pass++;
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL rst_first_addr: got %h exp 0000", bus.MemAddr); else n_pass++;
    cyc_end();
  endtask

  task automatic test_stream();
    mem_en = 1'b1; mem_lat = 0; mem_off = 16'h0000;
    apply_reset();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL str_addr0: got %h exp 0000", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL str_ready_c1: got %b exp 0", bus.InstrReady); else n_pass++;
    cyc_end();
    bus.InstrTake = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0001) $display("FAIL str_addr1: got %h exp 0001", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b1) $display("FAIL str_ready_c2: got %b exp 1", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0000) $display("FAIL str_pc_c2: got %h exp 0000", bus.InstrPC); else n_pass++;
    cyc_end();
    bus.InstrTake = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0002) $display("FAIL str_addr2: got %h exp 0002", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.Instr !== 16'h0001) $display("FAIL str_instr_c3: got %h exp 0001", bus.Instr); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0001) $display("FAIL str_pc_c3: got %h exp 0001", bus.InstrPC); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0003) $display("FAIL str_addr3: got %h exp 0003", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.Instr !== 16'h0002) $display("FAIL str_instr_c4: got %h exp 0002", bus.Instr); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b0) $display("FAIL str_full_req: got %b exp 0", bus.MemReq); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0002) $display("FAIL str_pc_c5: got %h exp 0002", bus.InstrPC); else n_pass++;
    cyc_end();
  endtask

  task automatic test_hold();
    mem_en = 1'b1; mem_lat = 2; mem_off = 16'h0000;
    apply_reset();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL hold_addr_c1: got %h exp 0000", bus.MemAddr); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL hold_addr_stable: got %h exp 0000", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL hold_ready_c2: got %b exp 0", bus.InstrReady); else n_pass++;
    cyc_end();
    step(1);
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0001) $display("FAIL hold_addr_c4: got %h exp 0001", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b1) $display("FAIL hold_ready_c4: got %b exp 1", bus.InstrReady); else n_pass++;
    cyc_end();
    step(2);
    bus.InstrTake = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b0) $display("FAIL hold_full_req: got %b exp 0", bus.MemReq); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0000) $display("FAIL hold_full_pc: got %h exp 0000", bus.InstrPC); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b1) $display("FAIL hold_resume_req: got %b exp 1", bus.MemReq); else n_pass++;
    n_checks++; if (bus.MemAddr !== 16'h0002) $display("FAIL hold_resume_addr: got %h exp 0002", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0001) $display("FAIL hold_resume_pc: got %h exp 0001", bus.InstrPC); else n_pass++;
    cyc_end();
  endtask

  task automatic test_redirect_discard();
    mem_en = 1'b0; mem_lat = 0; mem_off = 16'h0000;
    apply_reset();
    bus.PCWrite = 1'b1; bus.PCIn = 16'h0005;
    step(1);
    mem_en = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL disc_old_addr: got %h exp 0000", bus.MemAddr); else n_pass++;
    cyc_end();
    mem_lat = 2;
    bus.PCWrite = 1'b1; bus.PCIn = 16'h0100;
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0005) $display("FAIL disc_addr5: got %h exp 0005", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL disc_drop1: got %b exp 0", bus.InstrReady); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0005) $display("FAIL disc_hold5_a: got %h exp 0005", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.MemReq !== 1'b1) $display("FAIL disc_req: got %b exp 1", bus.MemReq); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0005) $display("FAIL disc_hold5_b: got %h exp 0005", bus.MemAddr); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0100) $display("FAIL disc_new_addr: got %h exp 0100", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL disc_drop2: got %b exp 0", bus.InstrReady); else n_pass++;
    cyc_end();
    step(2);
    cyc_begin();
    n_checks++; if (bus.InstrReady !== 1'b1) $display("FAIL disc_ready: got %b exp 1", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0100) $display("FAIL disc_pc: got %h exp 0100", bus.InstrPC); else n_pass++;
    n_checks++; if (bus.Instr !== 16'h0100) $display("FAIL disc_instr: got %h exp 0100", bus.Instr); else n_pass++;
    cyc_end();
  endtask

  task automatic test_same_cycle_redirect();
    mem_en = 1'b1; mem_lat = 0; mem_off = 16'h0000;
    apply_reset();
    step(1);
    bus.PCWrite = 1'b1; bus.PCIn = 16'h0040; bus.InstrTake = 1'b1;
    cyc_begin();
    n_checks++; if (bus.InstrReady !== 1'b1) $display("FAIL same_count1: got %b exp 1", bus.InstrReady); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL same_flush: got %b exp 0", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.MemAddr !== 16'h0040) $display("FAIL same_addr: got %h exp 0040", bus.MemAddr); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.Instr !== 16'h0040) $display("FAIL same_instr: got %h exp 0040", bus.Instr); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0040) $display("FAIL same_pc: got %h exp 0040", bus.InstrPC); else n_pass++;
    cyc_end();
  endtask

  task automatic test_wrap();
    mem_en = 1'b1; mem_lat = 0; mem_off = 16'h0000;
    apply_reset();
    bus.PCWrite = 1'b1; bus.PCIn = 16'hFFFF;
    step(1);
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'hFFFF) $display("FAIL wrap_addr_ffff: got %h exp ffff", bus.MemAddr); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL wrap_addr_0: got %h exp 0000", bus.MemAddr); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'hFFFF) $display("FAIL wrap_pc_ffff: got %h exp ffff", bus.InstrPC); else n_pass++;
    cyc_end();
    bus.InstrTake = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b0) $display("FAIL wrap_full: got %b exp 0", bus.MemReq); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.InstrPC !== 16'h0000) $display("FAIL wrap_pc_0: got %h exp 0000", bus.InstrPC); else n_pass++;
    n_checks++; if (bus.InstrReady !== 1'b1) $display("FAIL wrap_ready: got %b exp 1", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.MemAddr !== 16'h0001) $display("FAIL wrap_addr_1: got %h exp 0001", bus.MemAddr); else n_pass++;
    cyc_end();
  endtask

  task automatic test_opcode();
    mem_en = 1'b1; mem_lat = 0; mem_off = 16'h0000;
    apply_reset();
    bus.PCWrite = 1'b1; bus.PCIn = 16'h5C00;
    step(2);
    bus.PCWrite = 1'b1; bus.PCIn = 16'h8000;
    cyc_begin();
    n_checks++; if (bus.Instr !== 16'h5C00) $display("FAIL opc_instr_5c00: got %h exp 5c00", bus.Instr); else n_pass++;
    n_checks++; if (bus.OPCODE !== 5'h0B) $display("FAIL opc_0b: got %h exp 0b", bus.OPCODE); else n_pass++;
    n_checks++; if (bus.flagbit !== 1'b1) $display("FAIL opc_flag1: got %b exp 1", bus.flagbit); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL opc_redir_ready: got %b exp 0", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.MemAddr !== 16'h8000) $display("FAIL opc_redir_addr: got %h exp 8000", bus.MemAddr); else n_pass++;
    cyc_end();
    cyc_begin();
    n_checks++; if (bus.OPCODE !== 5'h10) $display("FAIL opc_10: got %h exp 10", bus.OPCODE); else n_pass++;
    n_checks++; if (bus.flagbit !== 1'b0) $display("FAIL opc_flag0: got %b exp 0", bus.flagbit); else n_pass++;
    cyc_end();
  endtask

  task automatic test_reset_midstream();
    mem_en = 1'b1; mem_lat = 0; mem_off = 16'h0A00;
    apply_reset();
    step(2);
    Reset = 1'b1;
    cyc_begin();
    n_checks++; if (bus.MemReq !== 1'b0) $display("FAIL mid_rst_req: got %b exp 0", bus.MemReq); else n_pass++;
    n_checks++; if (bus.Instr !== 16'h0A00) $display("FAIL mid_pre_instr: got %h exp 0a00", bus.Instr); else n_pass++;
    n_checks++; if (bus.OPCODE !== 5'h01) $display("FAIL mid_pre_opc: got %h exp 01", bus.OPCODE); else n_pass++;
    cyc_end();
    Reset = 1'b0;
    cyc_begin();
    n_checks++; if (bus.InstrReady !== 1'b0) $display("FAIL mid_ready: got %b exp 0", bus.InstrReady); else n_pass++;
    n_checks++; if (bus.Instr !== 16'h0000) $display("FAIL mid_instr: got %h exp 0000", bus.Instr); else n_pass++;
    n_checks++; if (bus.InstrPC !== 16'h0000) $display("FAIL mid_pc: got %h exp 0000", bus.InstrPC); else n_pass++;
    n_checks++; if (bus.OPCODE !== 5'h00) $display("FAIL mid_opc: got %h exp 00", bus.OPCODE); else n_pass++;
    n_checks++; if (bus.MemReq !== 1'b1) $display("FAIL mid_req: got %b exp 1", bus.MemReq); else n_pass++;
    n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL mid_addr: got %h exp 0000", bus.MemAddr); else n_pass++;
    cyc_end();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  initial begin
    Reset         = 1'b1;
    bus.MemAck    = 1'b0;
    bus.MemData   = 16'h0000;
    bus.PCWrite   = 1'b0;
    bus.PCIn      = 16'h0000;
    bus.InstrTake = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_stream();
    test_hold();
    test_redirect_discard();
    test_same_cycle_redirect();
    test_wrap();
    test_opcode();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
